universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 134 +++++++++++++
 tb/tb_universal_shift_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   WIDTH-bit universal shift register. It supports hold, single shift right,
//   single shift left and parallel load. It also runs multi-cycle bursts that
//   shift by `amt` positions, one position per enabled clock edge.
//
//   Optional feature: define USR_ROTATE_EN to enable rotation. With rot=1 the
//   bit that leaves one end of the register re-enters at the other end. With
//   USR_ROTATE_EN undefined, `rot` is ignored and shifts always take
//   sin_r/sin_l.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset (priority over everything)
//   en      clock enable; 0 freezes q, burst count, state, busy and done
//   mode    00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d       parallel load data
//   sin_r   serial bit entering the MSB on a right shift
//   sin_l   serial bit entering the LSB on a left shift
//   start   burst request (honoured only with mode 01/10 while not busy)
//   amt     burst shift count
//   rot     rotate select (USR_ROTATE_EN builds only)
//   q       register contents
//   q_bar   ~q, combinational
//   sout_r  q[0], combinational
//   sout_l  q[WIDTH-1], combinational
//   busy    burst in progress
//   done    one-cycle burst-complete pulse
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [AMT_W-1:0] count;
  logic             dir_left;
  logic             fill_r;
  logic             fill_l;

`ifdef USR_ROTATE_EN
  assign fill_r = rot ? q[0]       : sin_r;
  assign fill_l = rot ? q[WIDTH-1] : sin_l;
`else
  // rot has no effect in this build.
  logic unused_rot;
  assign unused_rot = rot;
  assign fill_r     = sin_r;
  assign fill_l     = sin_l;
`endif

  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                   input logic b);
    return {b, v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                  input logic b);
    return {v[WIDTH-2:0], b};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q        <= '0;
      count    <= '0;
      dir_left <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (en) begin
      case (state)
        BUSY: begin
          // Commands are ignored while a burst runs. Only the latched
          // direction and the live serial inputs matter here.
          q     <= dir_left ? shift_left(q, fill_l) : shift_right(q, fill_r);
          count <= count - AMT_W'(1);
          if (count == AMT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE accept commands identically. In DONE the done
          // pulse is dropped at this edge unless a zero-length burst
          // raises it again.
          done <= 1'b0;
          if (start && (mode == 2'b01 || mode == 2'b10)) begin
            // The start edge only latches the burst; no shift happens here.
            dir_left <= mode[1];
            count    <= amt;
            if (amt != '0) begin
              state <= BUSY;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            case (mode)
              2'b00: q <= q;
              2'b01: q <= shift_right(q, fill_r);
              2'b10: q <= shift_left(q, fill_l);
              2'b11: q <= d;
            endcase
          end
        end
      endcase
    end
  end

  assign q_bar  = ~q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;
  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, en, sin_r, sin_l, start, rot;
  logic [1:0]    mode;
  logic [W-1:0]  d;
  logic [AW-1:0] amt;
  wire  [W-1:0]  q, q_bar;
  wire           sout_r, sout_l, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .start(start), .amt(amt), .rot(rot),
    .q(q), .q_bar(q_bar), .sout_r(sout_r), .sout_l(sout_l),
    .busy(busy), .done(done)
  );

  // Behavioural reference: the register value as a number, plus the number
  // of shifts still owed by an accepted burst.
  logic [W-1:0] m_q;
  int           m_rem;
  logic         m_left, m_busy, m_done;

  function automatic logic bit_in_right(logic [W-1:0] v);
`ifdef USR_ROTATE_EN
    return rot ? v[0] : sin_r;
`else
    return sin_r;
`endif
  endfunction

  function automatic logic bit_in_left(logic [W-1:0] v);
`ifdef USR_ROTATE_EN
    return rot ? v[W-1] : sin_l;
`else
    return sin_l;
`endif
  endfunction

  function automatic logic [W-1:0] div2(logic [W-1:0] v, logic b);
    return W'((int'(v) / 2) + (b ? (1 << (W-1)) : 0));
  endfunction

  function automatic logic [W-1:0] mul2(logic [W-1:0] v, logic b);
    return W'(((int'(v) * 2) % (1 << W)) + (b ? 1 : 0));
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_q = '0; m_rem = 0; m_busy = 1'b0; m_done = 1'b0;
    end else if (en) begin
      if (m_rem > 0) begin
        m_q    = m_left ? mul2(m_q, bit_in_left(m_q)) : div2(m_q, bit_in_right(m_q));
        m_rem  = m_rem - 1;
        m_busy = (m_rem > 0);
        m_done = (m_rem == 0);
      end else begin
        m_busy = 1'b0;
        m_done = 1'b0;
        if (start && (mode == 2'd1 || mode == 2'd2)) begin
          m_left = (mode == 2'd2);
          m_rem  = int'(amt);
          m_busy = (m_rem > 0);
          m_done = (m_rem == 0);
        end else if (mode == 2'd1) m_q = div2(m_q, bit_in_right(m_q));
        else if (mode == 2'd2)     m_q = mul2(m_q, bit_in_left(m_q));
        else if (mode == 2'd3)     m_q = d;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},      q,      m_q);
    check({tag, ".q_bar"},  q_bar,  ~m_q);
    check({tag, ".sout_r"}, W'(sout_r), W'(m_q[0]));
    check({tag, ".sout_l"}, W'(sout_l), W'(m_q[W-1]));
    check({tag, ".busy"},   W'(busy),   W'(m_busy));
    check({tag, ".done"},   W'(done),   W'(m_done));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; d = '0; sin_r = 1'b0; sin_l = 1'b0;
    start = 1'b0; amt = '0; rot = 1'b0;
    m_q = '0; m_rem = 0; m_left = 1'b0; m_busy = 1'b0; m_done = 1'b0;

    // Reset, with en low: reset still wins.
    tick();
    check("rst_q", q, 8'h00);
    check("rst_q_bar", q_bar, 8'hFF);
    check("rst_busy", W'(busy), 8'h00);
    check("rst_done", W'(done), 8'h00);

    // Parallel load and serial outputs.
    rst = 1'b0; en = 1'b1; mode = 2'd3; d = 8'hA5;
    tick();
    check("load_q", q, 8'hA5);
    check("load_q_bar", q_bar, 8'h5A);
    check("load_sout_r", W'(sout_r), 8'h01);
    check("load_sout_l", W'(sout_l), 8'h01);

    // Single shifts.
    mode = 2'd1; sin_r = 1'b0; tick();
    check("shr_q", q, 8'h52);
    mode = 2'd2; sin_l = 1'b1; tick();
    check("shl_q", q, 8'hA5);

    // Left burst of 3, with commands that must be ignored while busy.
    mode = 2'd3; d = 8'h81; tick();
    check("ld81_q", q, 8'h81);
    mode = 2'd2; start = 1'b1; amt = 4'd3; sin_l = 1'b1; tick();
    check("b3_start_q", q, 8'h81);
    check("b3_start_busy", W'(busy), 8'h01);
    mode = 2'd3; d = 8'hFF; amt = 4'd7;
    tick(); check("b3_s1_q", q, 8'h03); check("b3_s1_busy", W'(busy), 8'h01);
    tick(); check("b3_s2_q", q, 8'h07); check("b3_s2_busy", W'(busy), 8'h01);
    tick(); check("b3_s3_q", q, 8'h0F); check("b3_s3_busy", W'(busy), 8'h00);
    check("b3_done", W'(done), 8'h01);
    mode = 2'd0; start = 1'b0;
    tick(); check("b3_done_clr", W'(done), 8'h00); check("b3_hold_q", q, 8'h0F);

    // Same burst with en low for two cycles after the first shift.
    mode = 2'd3; d = 8'h81; tick();
    mode = 2'd2; start = 1'b1; amt = 4'd3; tick();
    start = 1'b0; mode = 2'd0;
    tick(); check("fr_s1_q", q, 8'h03);
    en = 1'b0;
    tick(); check("fr_c1_q", q, 8'h03); check("fr_c1_busy", W'(busy), 8'h01);
    tick(); check("fr_c2_q", q, 8'h03); check("fr_c2_busy", W'(busy), 8'h01);
    en = 1'b1;
    tick(); check("fr_s2_q", q, 8'h07); check("fr_s2_busy", W'(busy), 8'h01);
    tick(); check("fr_s3_q", q, 8'h0F); check("fr_done", W'(done), 8'h01);
    en = 1'b0;
    tick(); check("fr_done_held", W'(done), 8'h01);
    en = 1'b1;
    tick(); check("fr_done_clr", W'(done), 8'h00); check("fr_busy_end", W'(busy), 8'h00);

    // Reset during the second shift of a 5-shift burst.
    mode = 2'd3; d = 8'h81; tick();
    mode = 2'd1; sin_r = 1'b0; start = 1'b1; amt = 4'd5; tick();
    start = 1'b0; mode = 2'd0;
    tick(); check("ab_s1_q", q, 8'h40);
    rst = 1'b1;
    tick(); check("ab_q", q, 8'h00); check("ab_busy", W'(busy), 8'h00);
    check("ab_done", W'(done), 8'h00);
    rst = 1'b0;
    tick(); check("ab_done_after", W'(done), 8'h00); check("ab_busy_after", W'(busy), 8'h00);

    // Zero-length burst.
    mode = 2'd3; d = 8'h3C; tick();
    mode = 2'd1; start = 1'b1; amt = 4'd0; tick();
    check("z_q", q, 8'h3C); check("z_busy", W'(busy), 8'h00); check("z_done", W'(done), 8'h01);
    start = 1'b0; mode = 2'd0; tick();
    check("z_done_clr", W'(done), 8'h00);

    // start with load mode is just a load.
    mode = 2'd3; d = 8'h5A; start = 1'b1; amt = 4'd4; tick();
    check("sl_q", q, 8'h5A); check("sl_busy", W'(busy), 8'h00);
    start = 1'b0;

    // Rotate select.
    mode = 2'd3; d = 8'h81; tick();
    mode = 2'd1; rot = 1'b1; sin_r = 1'b0; tick();
`ifdef USR_ROTATE_EN
    check("rot_q", q, 8'hC0);
`else
    check("rot_q", q, 8'h40);
`endif
    rot = 1'b0; mode = 2'd0; tick();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      en    = ($urandom_range(0, 5) != 0);
      mode  = 2'($urandom_range(0, 3));
      d     = W'($urandom);
      sin_r = 1'($urandom);
      sin_l = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      amt   = AW'($urandom_range(0, 6));
      rot   = 1'($urandom);
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
